telemetry_framer: RTL and testbench

//  Downstream consumer of the shared-multiplier datapath. Captures the latest altitude

---
 rtl/telemetry_framer_if.sv | 11 +
 rtl/telemetry_framer.sv | 157 +++++++++++++++
 tb/tb_telemetry_framer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/telemetry_framer_if.sv
// Byte stream toward the radio/UART link: data/valid/last from the framer,
// ready back from the sink. A byte transfers when valid and ready are both high.
interface telemetry_framer_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       last;

  modport master (output data, valid, last, input ready);
  modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/telemetry_framer.sv
// Telemetry framer: latches the latest altitude correction and battery estimate,
// and every FRAME_PERIOD cycles sends an 8-byte frame
// (sync, seq, alt, bat, flags, XOR checksum) on a ready/valid byte stream.
module telemetry_framer #(
  parameter int                 FRAME_PERIOD = 1000,
  parameter logic signed [15:0] BAT_LOW      = 16'sd200,
  parameter logic signed [15:0] ALT_MAX      = 16'sd1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [15:0]        alt_in,
  input  logic               alt_valid,
  input  logic [15:0]        bat_in,
  input  logic               bat_valid,
  telemetry_framer_if.master m,
  output logic               busy
);

  localparam int             CW       = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(FRAME_PERIOD - 1);
  localparam logic [7:0]     SYNC     = 8'hA5;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_d;
  logic [2:0]         idx, idx_d;
  logic [CW-1:0]      cnt;
  logic signed [15:0] alt_reg, bat_reg;
  logic signed [15:0] snap_alt, snap_bat;
  logic [7:0]         snap_flags;
  logic               alt_fresh, bat_fresh, overrun;
  logic [7:0]         seq;
  logic [7:0]         checksum;
  logic               tick, final_hs, accept;

  // A tick can only start a frame when the link is idle or the current frame
  // hands off its last byte in the same cycle; otherwise it is dropped.
  assign tick     = en && (cnt == CNT_LAST);
  assign final_hs = (state == SEND) && (idx == 3'd7) && m.ready;
  assign accept   = tick && ((state == IDLE) || final_hs);

  // seq is read live: it only changes on the final handshake, so it is stable
  // for the whole frame and already advanced when a back-to-back frame starts.
  assign checksum = seq ^ snap_alt[15:8] ^ snap_alt[7:0]
                  ^ snap_bat[15:8] ^ snap_bat[7:0] ^ snap_flags;

  // Frame period counter: free-runs while enabled, parks at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst)                 cnt <= '0;
    else if (!en)            cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                     cnt <= cnt + CW'(1);
  end

  // Capture latches, freshness/overrun flags, frame snapshot and sequence number.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alt_reg    <= '0;
      bat_reg    <= '0;
      alt_fresh  <= 1'b0;
      bat_fresh  <= 1'b0;
      overrun    <= 1'b0;
      snap_alt   <= '0;
      snap_bat   <= '0;
      snap_flags <= '0;
      seq        <= '0;
    end else begin
      if (accept) begin
        snap_alt   <= alt_reg;
        snap_bat   <= bat_reg;
        snap_flags <= {3'b000, overrun, (alt_reg > ALT_MAX), (bat_reg < BAT_LOW),
                       bat_fresh, alt_fresh};
      end
      // A strobe in the snapshot cycle wins: the new value stays marked fresh
      // for the following frame.
      if (alt_valid) begin
        alt_reg   <= alt_in;
        alt_fresh <= 1'b1;
      end else if (accept) begin
        alt_fresh <= 1'b0;
      end
      if (bat_valid) begin
        bat_reg   <= bat_in;
        bat_fresh <= 1'b1;
      end else if (accept) begin
        bat_fresh <= 1'b0;
      end
      if (accept)    overrun <= 1'b0;
      else if (tick) overrun <= 1'b1;
      if (final_hs)  seq <= seq + 8'd1;
    end
  end

  // FSM state and byte index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  // Next-state logic: walk bytes 0..7 on each handshake, chain frames back to back.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d = state;
    idx_d   = idx;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          idx_d   = 3'd0;
        end
      end
      SEND: begin
        if (m.ready) begin
          if (idx == 3'd7) begin
            idx_d   = 3'd0;
            state_d = accept ? SEND : IDLE;
          end else begin
            idx_d = idx + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Stream outputs decoded from registered state, so they hold while stalled.
  always_comb begin
    m.valid = (state == SEND);
    m.last  = (state == SEND) && (idx == 3'd7);
    busy    = (state == SEND);
    m.data  = 8'h00;
    if (state == SEND) begin
      case (idx)
        3'd0:    m.data = SYNC;
        3'd1:    m.data = seq;
        3'd2:    m.data = snap_alt[15:8];
        3'd3:    m.data = snap_alt[7:0];
        3'd4:    m.data = snap_bat[15:8];
        3'd5:    m.data = snap_bat[7:0];
        3'd6:    m.data = snap_flags;
        default: m.data = checksum;
      endcase
    end
  end

endmodule

// File: tb/tb_telemetry_framer.sv
// Self-checking bench for telemetry_framer: a frame-level reference model
// (byte queue built at each accepted tick) is compared with the stream every cycle.
module tb_telemetry_framer;

  localparam int                 P  = 16;
  localparam logic signed [15:0] BL = 16'sd200;
  localparam logic signed [15:0] AM = 16'sd1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] alt_in, bat_in;
  logic        alt_valid, bat_valid;
  logic        busy;

  telemetry_framer_if ifc ();

  telemetry_framer #(.FRAME_PERIOD(P), .BAT_LOW(BL), .ALT_MAX(AM)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .alt_in    (alt_in),
    .alt_valid (alt_valid),
    .bat_in    (bat_in),
    .bat_valid (bat_valid),
    .m         (ifc.master),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic signed [15:0] m_alt, m_bat;
  bit                 m_afresh, m_bfresh, m_ovr;
  logic [7:0]         m_seq;
  int                 m_run;
  logic [7:0]         exp_q[$];

  // Observed stream
  logic [7:0] cur[$];
  logic [7:0] last_frame[8];
  int         frames_done = 0;

  task automatic model_reset();
    m_alt = '0; m_bat = '0;
    m_afresh = 0; m_bfresh = 0; m_ovr = 0;
    m_seq = '0; m_run = 0;
    exp_q.delete();
    cur.delete();
  endtask

  task automatic build_frame();
    logic [7:0] b[8];
    b[0] = 8'hA5;
    b[1] = m_seq;
    b[2] = m_alt[15:8];
    b[3] = m_alt[7:0];
    b[4] = m_bat[15:8];
    b[5] = m_bat[7:0];
    b[6] = {3'b000, m_ovr, (m_alt > AM), (m_bat < BL), m_bfresh, m_afresh};
    b[7] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    m_afresh = 0; m_bfresh = 0; m_ovr = 0;
  endtask

  // One clock cycle: compare outputs against the model, advance the model, clock.
  task automatic step();
    bit hs, tick, acc;
    checks++;
    if (ifc.valid !== (exp_q.size() != 0)) begin
      errors++; $display("FAIL valid: got %b expected %b", ifc.valid, exp_q.size() != 0);
    end
    checks++;
    if (busy !== (exp_q.size() != 0)) begin
      errors++; $display("FAIL busy: got %b expected %b", busy, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      checks++;
      if (ifc.data !== exp_q[0]) begin
        errors++; $display("FAIL data[%0d]: got %h expected %h", 8 - exp_q.size(), ifc.data, exp_q[0]);
      end
      checks++;
      if (ifc.last !== (exp_q.size() == 1)) begin
        errors++; $display("FAIL last: got %b expected %b", ifc.last, exp_q.size() == 1);
      end
    end
    if (ifc.valid === 1'b1 && ifc.ready === 1'b1) begin
      cur.push_back(ifc.data);
      if (ifc.last === 1'b1) begin
        if (cur.size() == 8) for (int i = 0; i < 8; i++) last_frame[i] = cur[i];
        frames_done++;
        cur.delete();
      end
    end
    hs   = (exp_q.size() != 0) && ifc.ready;
    tick = en && (m_run == P - 1);
    acc  = tick && ((exp_q.size() == 0) || (hs && exp_q.size() == 1));
    if (hs) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) m_seq = m_seq + 8'd1;
    end
    if (acc)       build_frame();
    else if (tick) m_ovr = 1;
    if (alt_valid) begin m_alt = alt_in; m_afresh = 1; end
    if (bat_valid) begin m_bat = bat_in; m_bfresh = 1; end
    m_run = !en ? 0 : ((m_run == P - 1) ? 0 : m_run + 1);
    @(posedge clk); #1;
    alt_valid = 1'b0;
    bat_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int target = frames_done + n;
    for (int i = 0; i < budget && frames_done < target; i++) step();
    checks++;
    if (frames_done < target) begin
      errors++; $display("FAIL timeout %s: got %0d frames expected %0d", name, frames_done, target);
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] exp[8]);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (last_frame[i] !== exp[i]) begin
        errors++; $display("FAIL %s byte %0d: got %h expected %h", name, i, last_frame[i], exp[i]);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (ifc.valid !== 1'b0 || ifc.last !== 1'b0 || busy !== 1'b0 || ifc.data !== 8'h00) begin
      errors++;
      $display("FAIL reset outputs: got valid=%b last=%b busy=%b data=%h expected 0 0 0 00",
               ifc.valid, ifc.last, busy, ifc.data);
    end
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b0; ifc.ready = 1'b1;
    alt_in = '0; bat_in = '0; alt_valid = 1'b0; bat_valid = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_basic();
    logic [7:0] f1[8] = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h00, 8'hC8, 8'h03, 8'hE9};
    logic [7:0] f2[8] = '{8'hA5, 8'h01, 8'h01, 8'h23, 8'h00, 8'hC8, 8'h00, 8'hEB};
    do_reset();
    en = 1'b1; ifc.ready = 1'b1;
    alt_in = 16'h0123; alt_valid = 1'b1;
    bat_in = 16'h00C8; bat_valid = 1'b1;
    wait_frames(1, 40, "basic1");
    check_frame("basic1", f1);
    wait_frames(1, 40, "basic2");
    check_frame("basic2", f2);
  endtask

  task automatic test_flags();
    logic [7:0] ck;
    bat_in = 16'hFF00; bat_valid = 1'b1;
    alt_in = 16'h03E9; alt_valid = 1'b1;
    wait_frames(1, 40, "flags");
    checks++;
    if (last_frame[6] !== 8'h0F) begin
      errors++; $display("FAIL flags: got %h expected 0f", last_frame[6]);
    end
    checks++;
    if ({last_frame[2], last_frame[3], last_frame[4], last_frame[5]} !== 32'h03E9_FF00) begin
      errors++; $display("FAIL flags payload: got %h%h%h%h expected 03e9ff00",
                         last_frame[2], last_frame[3], last_frame[4], last_frame[5]);
    end
    ck = last_frame[1] ^ last_frame[2] ^ last_frame[3] ^ last_frame[4] ^ last_frame[5] ^ last_frame[6];
    checks++;
    if (last_frame[7] !== ck) begin
      errors++; $display("FAIL flags checksum: got %h expected %h", last_frame[7], ck);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 40 && exp_q.size() != 5; i++) step();
    ifc.ready = 1'b0;
    for (int i = 0; i < 40; i++) step();
    ifc.ready = 1'b1;
    wait_frames(1, 20, "stall_resume");
    wait_frames(1, 40, "stall_overrun");
    checks++;
    if (last_frame[6][4] !== 1'b1) begin
      errors++; $display("FAIL overrun set: got %b expected 1", last_frame[6][4]);
    end
    wait_frames(1, 40, "stall_clear");
    checks++;
    if (last_frame[6][4] !== 1'b0) begin
      errors++; $display("FAIL overrun clear: got %b expected 0", last_frame[6][4]);
    end
  endtask

  task automatic test_snapshot();
    logic [15:0] old_alt, new_alt;
    old_alt = m_alt;
    new_alt = old_alt ^ 16'h5A5A;
    for (int i = 0; i < 60 && !(m_run == P - 1 && exp_q.size() == 0); i++) step();
    alt_in = new_alt; alt_valid = 1'b1;
    step();
    wait_frames(1, 40, "snap_old");
    checks++;
    if ({last_frame[2], last_frame[3]} !== old_alt) begin
      errors++; $display("FAIL snapshot old alt: got %h%h expected %h", last_frame[2], last_frame[3], old_alt);
    end
    wait_frames(1, 40, "snap_new");
    checks++;
    if ({last_frame[2], last_frame[3]} !== new_alt || last_frame[6][0] !== 1'b1) begin
      errors++; $display("FAIL snapshot new alt: got %h%h fresh %b expected %h fresh 1",
                         last_frame[2], last_frame[3], last_frame[6][0], new_alt);
    end
  endtask

  task automatic test_reset_midframe();
    int seen;
    for (int i = 0; i < 60 && exp_q.size() != 4; i++) step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ifc.valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort: got valid=%b busy=%b expected 0 0", ifc.valid, busy);
    end
    en = 1'b0;
    do_reset();
    seen = frames_done;
    for (int i = 0; i < 50; i++) step();
    checks++;
    if (frames_done !== seen) begin
      errors++; $display("FAIL en low: got %0d frames expected %0d", frames_done - seen, 0);
    end
    en = 1'b1;
    wait_frames(1, 40, "after_reset");
    checks++;
    if (last_frame[1] !== 8'h00) begin
      errors++; $display("FAIL seq after reset: got %h expected 00", last_frame[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq = 8'h01;
    bit         wrapped = 0;
    for (int f = 0; f < 260; f++) begin
      for (int i = 0; i < 200; i++) begin
        if (frames_done > 0 && cur.size() == 0 && i > 0) break;
        ifc.ready = ($urandom_range(3) != 0);
        if ($urandom_range(7) == 0) begin alt_in = 16'($urandom); alt_valid = 1'b1; end
        if ($urandom_range(7) == 0) begin bat_in = 16'($urandom); bat_valid = 1'b1; end
        step();
        if (cur.size() == 0 && ifc.valid !== 1'b1 && exp_q.size() == 0 && i > 0 && frames_done > 0) begin
          // idle between frames; keep stepping until next frame finishes
        end
      end
      ifc.ready = 1'b1;
      wait_frames(1, 200, "b2b");
      checks++;
      if (last_frame[1] !== exp_seq) begin
        errors++; $display("FAIL seq: got %h expected %h", last_frame[1], exp_seq);
      end
      if (exp_seq == 8'h00) wrapped = 1;
      exp_seq = exp_seq + 8'd1;
    end
    checks++;
    if (wrapped !== 1'b1) begin
      errors++; $display("FAIL seq wrap: got %b expected 1", wrapped);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifc.ready = 1'b1;
    test_reset();
    test_basic();
    test_flags();
    test_stall();
    test_snapshot();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
